rps_match_scorer: RTL and testbench

Downstream consumer of the rock-paper-scissors-lizard-Spock judge. Samples the judge's `p1Win`/`p2Win`/`tie` outcome once per strobed round and accumulates per-player scores and a consecutive-tie streak. It runs a first-to-`WINS_NEEDED` match state machine and declares the match winner, or a draw when the tie streak limit is hit. Sits between the combinational judge and the display/scoreboard logic.

---
 rtl/rps_match_scorer_pkg.sv | 15 +
 rtl/rps_score_counter.sv | 22 ++
 rtl/rps_match_scorer.sv | 71 +++++++
 tb/tb_rps_match_scorer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rps_match_scorer_pkg.sv
// rps_match_scorer_pkg: move codes, winner codes and FSM state encodings
package rps_match_scorer_pkg;
  localparam logic [2:0] ROCK     = 3'b001;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b011;
  localparam logic [2:0] LIZARD   = 3'b100;
  localparam logic [2:0] SPOCK    = 3'b101;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
endpackage

// File: rtl/rps_score_counter.sv
// rps_score_counter: counter with sync clear, increment and next-increment-hits-limit flag
module rps_score_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         atLimit
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear has priority so an aborted match never keeps a stray increment
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt     = cnt_q;
  assign atLimit = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/rps_match_scorer.sv
// rps_match_scorer: first-to-N match FSM scoring judged rock-paper-scissors-lizard-Spock rounds
module rps_match_scorer
  import rps_match_scorer_pkg::*;
#(
  parameter int WINS_NEEDED = 3,
  parameter int SCORE_W     = 3,
  parameter int MAX_TIES    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               roundValid,
  input  logic               p1Win,
  input  logic               p2Win,
  input  logic               tie,
  output logic [SCORE_W-1:0] p1Score,
  output logic [SCORE_W-1:0] p2Score,
  output logic [3:0]         tieStreak,
  output logic               busy,
  output logic               matchOver,
  output logic [1:0]         winner,
  output logic               badRound
);
  logic [1:0] state_q, state_d, winner_q, winner_d;
  logic       bad_q, bad_d;
  logic       play, one_hot, rnd, inc_p1, inc_p2, inc_t, lim_p1, lim_p2, lim_t, win_p1, win_p2, draw;
  // round qualification: start always overrides a coincident round
  always_comb begin
    play    = state_q == ST_PLAY;
    one_hot = $onehot({p1Win, p2Win, tie});
    rnd     = play && roundValid && !start && one_hot;
    inc_p1  = rnd && p1Win;
    inc_p2  = rnd && p2Win;
    inc_t   = rnd && tie;
    win_p1  = inc_p1 && lim_p1;
    win_p2  = inc_p2 && lim_p2;
    draw    = inc_t && lim_t;
  end
  rps_score_counter #(.W(SCORE_W), .LIMIT(WINS_NEEDED)) u_p1 (
    .clk(clk), .rst(rst), .clr(start), .inc(inc_p1), .cnt(p1Score), .atLimit(lim_p1)
  );
  rps_score_counter #(.W(SCORE_W), .LIMIT(WINS_NEEDED)) u_p2 (
    .clk(clk), .rst(rst), .clr(start), .inc(inc_p2), .cnt(p2Score), .atLimit(lim_p2)
  );
  rps_score_counter #(.W(4), .LIMIT(MAX_TIES)) u_tie (
    .clk(clk), .rst(rst), .clr(start || inc_p1 || inc_p2), .inc(inc_t), .cnt(tieStreak), .atLimit(lim_t)
  );
  // next state, result and sticky bad-round flag; encoding 11 falls back to IDLE
  always_comb begin
    state_d  = start ? ST_PLAY
             : play  ? ((win_p1 || win_p2 || draw) ? ST_DONE : ST_PLAY)
             : state_q == ST_DONE ? ST_DONE : ST_IDLE;
    winner_d = start ? WIN_NONE : win_p1 ? WIN_P1 : win_p2 ? WIN_P2 : draw ? WIN_DRAW : winner_q;
    bad_d    = !start && (bad_q || (play && roundValid && !one_hot));
  end
  // control registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= WIN_NONE;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      bad_q    <= bad_d;
    end
  assign busy      = state_q == ST_PLAY;
  assign matchOver = state_q == ST_DONE;
  assign winner    = winner_q;
  assign badRound  = bad_q;
endmodule

// File: tb/tb_rps_match_scorer.sv
// tb_rps_match_scorer: directed checks of the match scorer fed by a behavioural judge
module tb_rps_match_scorer;
  localparam logic [2:0] ROCK = 3'b001, PAPER = 3'b010, SCISSORS = 3'b011, LIZARD = 3'b100, SPOCK = 3'b101;
  logic clk = 0, rst = 0, start = 0, roundValid = 0, ov_en = 0;
  logic [2:0] m1 = ROCK, m2 = ROCK, ov = 3'b000, judged;
  logic p1Win, p2Win, tie, busy, matchOver, badRound;
  logic [2:0] p1Score, p2Score;
  logic [3:0] tieStreak;
  logic [1:0] winner;
  logic [14:0] obs, e;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    case ({a, b})
      {ROCK, SCISSORS}, {ROCK, LIZARD}, {PAPER, ROCK}, {PAPER, SPOCK}, {SCISSORS, PAPER},
      {SCISSORS, LIZARD}, {LIZARD, SPOCK}, {LIZARD, PAPER}, {SPOCK, SCISSORS}, {SPOCK, ROCK}: beats = 1'b1;
      default: beats = 1'b0;
    endcase
  endfunction

  always_comb judged = (m1 == m2) ? 3'b001 : beats(m1, m2) ? 3'b100 : 3'b010;
  assign {p1Win, p2Win, tie} = ov_en ? ov : judged;
  assign obs = {p1Score, p2Score, tieStreak, busy, matchOver, winner, badRound};

  function automatic logic [14:0] pk(input int s1, s2, ts, input logic b, mo, input logic [1:0] w, input logic bad);
    pk = {3'(s1), 3'(s2), 4'(ts), b, mo, w, bad};
  endfunction

  rps_match_scorer dut (
    .clk(clk), .rst(rst), .start(start), .roundValid(roundValid),
    .p1Win(p1Win), .p2Win(p2Win), .tie(tie),
    .p1Score(p1Score), .p2Score(p2Score), .tieStreak(tieStreak),
    .busy(busy), .matchOver(matchOver), .winner(winner), .badRound(badRound)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1;
    roundValid = 0;
    tick();
    start = 0;
  endtask

  task automatic play(input logic [2:0] a, input logic [2:0] b);
    m1 = a;
    m2 = b;
    roundValid = 1;
    tick();
    roundValid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    e = pk(0, 0, 0, 0, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL reset_held obs=%h exp=%h", obs, e); end
    rst = 0;
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL reset_release obs=%h exp=%h", obs, e); end
    play(ROCK, SCISSORS);
    play(ROCK, SCISSORS);
    tests++; if (obs !== e) begin fails++; $display("FAIL idle_ignores_rounds obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_p1_sweep();
    logic [2:0] a [3] = '{ROCK, PAPER, LIZARD};
    logic [2:0] b [3] = '{SCISSORS, SPOCK, PAPER};
    do_start();
    e = pk(0, 0, 0, 1, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL p1_start obs=%h exp=%h", obs, e); end
    m1 = a[0]; m2 = b[0]; roundValid = 1;
    for (int i = 0; i < 3; i++) begin
      m1 = a[i];
      m2 = b[i];
      tick();
      e = (i == 2) ? pk(3, 0, 0, 0, 1, 2'b01, 0) : pk(i + 1, 0, 0, 1, 0, 2'b00, 0);
      tests++; if (obs !== e) begin fails++; $display("FAIL p1_sweep r%0d obs=%h exp=%h", i, obs, e); end
    end
    roundValid = 0;
    play(PAPER, ROCK);
    tests++; if (obs !== e) begin fails++; $display("FAIL done_holds obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_tie_draw();
    logic [2:0] a [4] = '{SCISSORS, ROCK, LIZARD, PAPER};
    logic [2:0] b [4] = '{ROCK, ROCK, LIZARD, SCISSORS};
    int ts [4] = '{0, 1, 2, 0};
    int s2 [4] = '{1, 1, 1, 2};
    do_start();
    for (int i = 1; i <= 5; i++) begin
      play(SPOCK, SPOCK);
      e = (i == 5) ? pk(0, 0, 5, 0, 1, 2'b11, 0) : pk(0, 0, i, 1, 0, 2'b00, 0);
      tests++; if (obs !== e) begin fails++; $display("FAIL tie_streak t%0d obs=%h exp=%h", i, obs, e); end
    end
    do_start();
    for (int i = 0; i < 4; i++) begin
      play(a[i], b[i]);
      e = pk(0, s2[i], ts[i], 1, 0, 2'b00, 0);
      tests++; if (obs !== e) begin fails++; $display("FAIL tie_reset r%0d obs=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    m1 = ROCK; m2 = LIZARD; roundValid = 1; tick();
    m1 = SCISSORS; m2 = SPOCK; tick();
    m1 = SPOCK; m2 = ROCK; tick();
    roundValid = 0;
    e = pk(2, 1, 0, 1, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL b2b_2_1 obs=%h exp=%h", obs, e); end
    start = 1; m1 = PAPER; m2 = ROCK; roundValid = 1;
    tick();
    start = 0; roundValid = 0;
    e = pk(0, 0, 0, 1, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL abort_simul obs=%h exp=%h", obs, e); end
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL abort_settle obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_bad_round();
    do_start();
    play(PAPER, ROCK);
    ov_en = 1;
    ov = 3'b110;
    roundValid = 1;
    tick();
    e = pk(1, 0, 0, 1, 0, 2'b00, 1);
    tests++; if (obs !== e) begin fails++; $display("FAIL bad_two_hot obs=%h exp=%h", obs, e); end
    ov = 3'b000;
    tick();
    tests++; if (obs !== e) begin fails++; $display("FAIL bad_none obs=%h exp=%h", obs, e); end
    ov_en = 0;
    roundValid = 0;
    play(SPOCK, SPOCK);
    e = pk(1, 0, 1, 1, 0, 2'b00, 1);
    tests++; if (obs !== e) begin fails++; $display("FAIL bad_sticky obs=%h exp=%h", obs, e); end
    do_start();
    e = pk(0, 0, 0, 1, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL bad_cleared obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_async_reset();
    do_start();
    play(ROCK, LIZARD);
    play(ROCK, PAPER);
    play(LIZARD, SPOCK);
    play(LIZARD, ROCK);
    e = pk(2, 2, 0, 1, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL pre_reset_2_2 obs=%h exp=%h", obs, e); end
    #2 rst = 1;
    #1;
    e = pk(0, 0, 0, 0, 0, 2'b00, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
    tick();
    rst = 0;
    play(PAPER, ROCK);
    tests++; if (obs !== e) begin fails++; $display("FAIL post_reset_idle obs=%h exp=%h", obs, e); end
    do_start();
    for (int i = 1; i <= 3; i++) begin
      play(ROCK, SPOCK);
      e = (i == 3) ? pk(0, 3, 0, 0, 1, 2'b10, 0) : pk(0, i, 0, 1, 0, 2'b00, 0);
      tests++; if (obs !== e) begin fails++; $display("FAIL p2_match r%0d obs=%h exp=%h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_p1_sweep();
    test_tie_draw();
    test_back_to_back();
    test_bad_round();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
